// File: rtl/mem_unit.sv
// mem_unit: byte-addressed synchronous RAM with byte-enable writes, a valid/ready
// request port, a pipelined in-order response (RD_LAT = 1 or 2), alignment and range
// error reporting, and an optional zeroing sweep after reset.
// Optional feature: define MEM_STATS_EN to add saturating rd_cnt/wr_cnt/err_cnt outputs.
module mem_unit #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned RD_LAT         = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt,
    output logic [15:0]           err_cnt
`endif
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              req_err;
    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_err_q, s1_err_d;
    logic [DATA_W-1:0] s1_rdata_q, s1_rdata_d;

    // Full-width range compare so addresses beyond DEPTH never alias onto low words.
    assign word_idx = req_addr >> OFF_W;
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign req_err  = (|(req_addr & ADDR_W'(BE_W - 1))) | (64'(word_idx) >= 64'(DEPTH));

    // rst_n gating keeps ready low while in reset even when the reset state is RUN.
    assign req_ready = (state_q == StRun) & rst_n;
    assign busy      = (state_q == StClear);
    assign accept    = req_valid & req_ready;

    // Clear-sweep sequencing: one word per cycle, RUN after word DEPTH-1.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StClear: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = StRun;
                    ptr_d   = '0;
                end
            end
            StRun: begin
            end
        endcase
    end

    // State and sweep pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR_ON_RESET ? StClear : StRun;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage array (not reset): sweep zeroing or byte-enabled request writes.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem_q[ptr_q] <= '0;
        end else if (accept && req_we && !req_err) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req_be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // First response stage: array sampled on the accept edge; data/err hold otherwise.
    always_comb begin
        s1_valid_d = accept;
        s1_err_d   = s1_err_q;
        s1_rdata_d = s1_rdata_q;
        if (accept) begin
            s1_err_d   = req_err;
            s1_rdata_d = (req_we || req_err) ? '0 : mem_q[mem_idx];
        end
    end

    // First response stage registers; in-flight responses are dropped by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_rdata_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_rdata_q <= s1_rdata_d;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              s2_valid_q;
        logic              s2_err_q, s2_err_d;
        logic [DATA_W-1:0] s2_rdata_q, s2_rdata_d;

        // Second stage only loads on a valid response so outputs hold between pulses.
        always_comb begin
            s2_err_d   = s2_err_q;
            s2_rdata_d = s2_rdata_q;
            if (s1_valid_q) begin
                s2_err_d   = s1_err_q;
                s2_rdata_d = s1_rdata_q;
            end
        end

        // Second response stage registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                s2_err_q   <= 1'b0;
                s2_rdata_q <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_err_q   <= s2_err_d;
                s2_rdata_q <= s2_rdata_d;
            end
        end

        assign rsp_valid = s2_valid_q;
        assign rsp_err   = s2_err_q;
        assign rsp_rdata = s2_rdata_q;
    end else begin : g_lat1
        assign rsp_valid = s1_valid_q;
        assign rsp_err   = s1_err_q;
        assign rsp_rdata = s1_rdata_q;
    end

`ifdef MEM_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating request counters; sweep writes never pass through accept.
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            if (req_err) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end else if (req_we) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: two instances (RD_LAT 1 and 2) share one request stream and are
// compared every cycle against a transaction-level model (word array + accept log).
module tb_mem_unit;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;

    logic        rdy_a, rsp_v_a, rsp_e_a, busy_a;
    logic [31:0] rsp_d_a;
    logic        rdy_b, rsp_v_b, rsp_e_b, busy_b;
    logic [31:0] rsp_d_b;
`ifdef MEM_STATS_EN
    logic [15:0] rd_cnt_a, wr_cnt_a, err_cnt_a, rd_cnt_b, wr_cnt_b, err_cnt_b;
`endif

    always #5 clk = ~clk;

    mem_unit #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(1), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_v_a),
        .rsp_rdata(rsp_d_a), .rsp_err(rsp_e_a), .busy(busy_a)
`ifdef MEM_STATS_EN
        , .rd_cnt(rd_cnt_a), .wr_cnt(wr_cnt_a), .err_cnt(err_cnt_a)
`endif
    );

    mem_unit #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(2), .CLEAR_ON_RESET(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_v_b),
        .rsp_rdata(rsp_d_b), .rsp_err(rsp_e_b), .busy(busy_b)
`ifdef MEM_STATS_EN
        , .rd_cnt(rd_cnt_b), .wr_cnt(wr_cnt_b), .err_cnt(err_cnt_b)
`endif
    );

    // Reference model state.
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;      // number of clock edges so far
    int          sweep = 0;    // edges since reset release
    logic [31:0] mem_m [DEPTH];
    bit          acc_v [int];  // keyed by accept edge number
    logic [31:0] acc_d [int];
    bit          acc_e [int];
    logic [31:0] last_d [2];
    logic        last_e [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Compare every output of both instances with the model for the current cycle.
    task automatic check_cycle();
        bit          rdy_exp;
        bit          ev;
        int          a;
        logic        ov, oe;
        logic [31:0] od;
        rdy_exp = (rst_n === 1'b1) && (sweep >= DEPTH);
        chk("ready_a", {63'd0, rdy_a}, {63'd0, rdy_exp});
        chk("ready_b", {63'd0, rdy_b}, {63'd0, rdy_exp});
        chk("busy_a", {63'd0, busy_a}, {63'd0, sweep < DEPTH});
        chk("busy_b", {63'd0, busy_b}, {63'd0, sweep < DEPTH});
        for (int k = 0; k < 2; k++) begin
            a  = cyc - k;  // response of an accept at edge a appears RD_LAT-1 cycles later
            ev = acc_v.exists(a);
            if (ev) begin
                last_d[k] = acc_d[a];
                last_e[k] = acc_e[a];
            end
            if (k == 0) begin
                ov = rsp_v_a; od = rsp_d_a; oe = rsp_e_a;
            end else begin
                ov = rsp_v_b; od = rsp_d_b; oe = rsp_e_b;
            end
            chk(k == 0 ? "rsp_valid_a" : "rsp_valid_b", {63'd0, ov}, {63'd0, ev});
            chk(k == 0 ? "rsp_rdata_a" : "rsp_rdata_b", {32'd0, od}, {32'd0, last_d[k]});
            chk(k == 0 ? "rsp_err_a" : "rsp_err_b", {63'd0, oe}, {63'd0, last_e[k]});
        end
    endtask

    // One clock cycle: drive, check at negedge, model the edge, return at edge+1.
    task automatic step(input bit v, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
        bit          err;
        logic [31:0] rd;
        req_valid = v; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (v && sweep >= DEPTH) begin
                err = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
                rd  = (we || err) ? 32'd0 : mem_m[addr / 4];
                if (we && !err) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) mem_m[addr / 4][8*i +: 8] = wd[8*i +: 8];
                end
                acc_v[cyc] = 1'b1;
                acc_d[cyc] = rd;
                acc_e[cyc] = err;
            end
            sweep++;
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    // Hold reset for n cycles; the sweep that follows leaves every word zero.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        acc_v.delete(); acc_d.delete(); acc_e.delete();
        last_d[0] = '0; last_d[1] = '0; last_e[0] = 1'b0; last_e[1] = 1'b0;
        sweep = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        #1;
        chk("rst_rsp_valid_a", {63'd0, rsp_v_a}, 64'd0);
        chk("rst_rsp_valid_b", {63'd0, rsp_v_b}, 64'd0);
        for (int i = 0; i < n; i++) idle();
        rst_n = 1'b1;
    endtask

    // Idle until the sweep finishes (bounded) and check it took exactly DEPTH cycles.
    task automatic wait_sweep(input string tag);
        int n;
        n = 0;
        while (busy_a === 1'b1 && n < DEPTH + 20) begin
            idle();
            n++;
        end
        chk(tag, 64'(n), 64'(DEPTH));
    endtask

    initial begin
        logic [31:0] a, w;
        int          r;

        // Reset and full clear sweep.
        do_reset(3);
        chk("reset_rdata_a", {32'd0, rsp_d_a}, 64'd0);
        chk("reset_err_a", {63'd0, rsp_e_a}, 64'd0);
        wait_sweep("sweep_len");
        chk("ready_after_sweep", {63'd0, rdy_a}, 64'd1);
        step(1'b1, 1'b0, 32'h3FC, 32'd0, 4'd0);
        chk("rd3fc_valid", {63'd0, rsp_v_a}, 64'd1);
        chk("rd3fc_rdata", {32'd0, rsp_d_a}, 64'd0);
        chk("rd3fc_err", {63'd0, rsp_e_a}, 64'd0);

        // Byte-enable merge, back to back.
        step(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        step(1'b1, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
        step(1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
        chk("be_merge_valid", {63'd0, rsp_v_a}, 64'd1);
        chk("be_merge_rdata", {32'd0, rsp_d_a}, 64'hDEADBEAA);

        // Latency-2 ordering.
        step(1'b1, 1'b1, 32'h0, 32'd1, 4'hF);
        step(1'b1, 1'b1, 32'h4, 32'd2, 4'hF);
        step(1'b1, 1'b1, 32'h8, 32'd3, 4'hF);
        step(1'b1, 1'b0, 32'h0, 32'd0, 4'd0);
        step(1'b1, 1'b0, 32'h4, 32'd0, 4'd0);
        chk("lat2_rd1", {32'd0, rsp_d_b}, 64'd1);
        step(1'b1, 1'b0, 32'h8, 32'd0, 4'd0);
        chk("lat2_rd2", {32'd0, rsp_d_b}, 64'd2);
        idle();
        chk("lat2_rd3_valid", {63'd0, rsp_v_b}, 64'd1);
        chk("lat2_rd3", {32'd0, rsp_d_b}, 64'd3);
        idle();
        chk("lat2_done", {63'd0, rsp_v_b}, 64'd0);
        chk("lat2_hold", {32'd0, rsp_d_b}, 64'd3);

        // Errors: misaligned read, out-of-range write leaves word 0 alone.
        step(1'b1, 1'b0, 32'h2, 32'd0, 4'd0);
        chk("misaligned_err", {63'd0, rsp_e_a}, 64'd1);
        chk("misaligned_rdata", {32'd0, rsp_d_a}, 64'd0);
        step(1'b1, 1'b1, 32'h400, 32'h55555555, 4'hF);
        chk("oor_err", {63'd0, rsp_e_a}, 64'd1);
        step(1'b1, 1'b0, 32'h0, 32'd0, 4'd0);
        chk("word0_kept", {32'd0, rsp_d_a}, 64'd1);
        chk("word0_err", {63'd0, rsp_e_a}, 64'd0);
        idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 31)) << 2;
            else if (r == 7) a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'h400 + (32'($urandom_range(0, 255)) << 2);
            else             a = $urandom;
            w = $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, w,
                 4'($urandom_range(0, 15)));
        end
        idle();
        idle();

        // Reset with responses in flight, then reset mid-sweep.
        step(1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
        do_reset(2);
        for (int i = 0; i < 100; i++) idle();
        chk("mid_sweep_busy", {63'd0, busy_a}, 64'd1);
        do_reset(2);
        wait_sweep("restart_sweep_len");
        step(1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
        chk("cleared_word", {32'd0, rsp_d_a}, 64'd0);
        idle();
        idle();

`ifdef MEM_STATS_EN
        do_reset(2);
        chk("stats_rst_rd", 64'(rd_cnt_a), 64'd0);
        wait_sweep("stats_sweep_len");
        chk("stats_sweep_wr", 64'(wr_cnt_a), 64'd0);
        step(1'b1, 1'b0, 32'h0, 32'd0, 4'd0);
        step(1'b1, 1'b1, 32'h4, 32'd9, 4'hF);
        step(1'b1, 1'b0, 32'h8, 32'd0, 4'd0);
        step(1'b1, 1'b0, 32'h5, 32'd0, 4'd0);
        step(1'b1, 1'b1, 32'hC, 32'd7, 4'h0);
        step(1'b1, 1'b0, 32'h4, 32'd0, 4'd0);
        idle();
        chk("stats_rd", 64'(rd_cnt_a), 64'd3);
        chk("stats_wr", 64'(wr_cnt_a), 64'd2);
        chk("stats_err", 64'(err_cnt_a), 64'd1);
        for (int i = 0; i < 65540; i++) step(1'b1, 1'b0, 32'h0, 32'd0, 4'd0);
        idle();
        chk("stats_rd_sat", 64'(rd_cnt_a), 64'hFFFF);
        chk("stats_wr_after_sat", 64'(wr_cnt_a), 64'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_unit.md
Name: mem_unit

Overview:
- Parametrised successor to the single-port instruction/data memory.
- Byte-addressed, width/depth-configurable synchronous RAM with byte-enable writes and a valid/ready request port.
- Pipelined response with configurable read latency, alignment and range error reporting, and an optional hardware clear sweep after reset.
- Serves as instruction or data memory for the core datapath.

Parameters:
- DATA_W, 32, data word width in bits; multiple of 8, minimum 8.
- DEPTH, 256, number of words.
- ADDR_W, 32, byte-address width.
- RD_LAT, 1, response latency in cycles after accept; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response pulse, one per accepted request.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- busy  out  1  clear sweep in progress.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=CLEAR_ON_RESET.
- Memory contents are not reset by rst_n.
- Word index = req_addr >> log2(DATA_W/8).
- Misaligned: any low offset bit nonzero. Out of range: word index >= DEPTH.
- Accept occurs on a rising edge where req_valid && req_ready.
- FSM states: CLEAR and RUN.
- CLEAR:
  - Entered on reset release when CLEAR_ON_RESET=1.
  - Pointer starts at 0; one word is written with zero per cycle.
  - req_ready=0, busy=1.
  - After word DEPTH-1 is written, go to RUN on the next edge. The sweep takes exactly DEPTH cycles.
- RUN:
  - req_ready=1, busy=0. This is the reset-release state when CLEAR_ON_RESET=0.
- Reset asserted mid-sweep: the sweep aborts; after release it restarts from word 0.
- Reset asserted with responses in flight: responses are dropped and rsp_valid=0.
- Accepted write, no error: on the accept edge, only bytes with req_be set are updated. req_be=0 is legal, changes nothing, and still returns a response.
- Accepted write, with error: memory is left unchanged.
- Accepted read: array is sampled on the accept edge, so the read sees every write accepted on earlier edges.
- Response timing:
  - For every accepted request, rsp_valid=1 for exactly one cycle, RD_LAT cycles after the accept edge.
  - rsp_rdata = read word, or 0 for writes and for errored requests.
  - rsp_err = misaligned || out of range.
- Throughput: fully pipelined, one request per cycle, responses in order. There is no response back-pressure; the consumer must always sink.
- When rsp_valid=0, rsp_rdata and rsp_err hold their last values.
- Write then read of the same word on consecutive cycles returns the new data. No hazard is possible (single port, write before read).
- Out-of-range checking uses full-width compare. No address wrap-around: an address beyond DEPTH never aliases.

Optional Feature:
- Macro: MEM_STATS_EN.
- When defined, adds three outputs, each 16 bits, cleared by rst_n, saturating at 16'hFFFF:
  - rd_cnt: accepted reads without error.
  - wr_cnt: accepted writes without error.
  - err_cnt: accepted requests with rsp_err=1.
- Counts update on the accept edge. Clear-sweep writes are not counted.
- When not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset with CLEAR_ON_RESET=1, DEPTH=256:
   - busy=1 and req_ready=0 for exactly 256 cycles, then busy=0 and req_ready=1.
   - Read of addr 0x3FC then returns 0 with rsp_err=0.
2. RD_LAT=1 back-to-back:
   - Stimulus: write 0xDEADBEEF to addr 0x10 with be=4'hF, then write 0x000000AA to 0x10 with be=4'b0001, then read 0x10.
   - Read response arrives 1 cycle after its accept with rdata=0xDEADBEAA.
   - Three rsp_valid pulses on consecutive cycles.
3. RD_LAT=2, reads of 0x0, 0x4, 0x8 on consecutive cycles after writing 1, 2, 3:
   - rsp_valid high for 3 cycles starting 2 cycles after the first accept, with rdata 1, 2, 3 in order.
4. Errors:
   - Read of 0x2 gives rsp_err=1, rdata=0.
   - Write to 0x400 with DEPTH=256 gives rsp_err=1; a subsequent read of 0x0 is unchanged.
5. Reset pulsed at sweep cycle 100: after release, busy stays high a full 256 cycles; in-flight responses never appear.
6. With MEM_STATS_EN:
   - Stimulus: 3 good reads, 2 good writes, 1 misaligned read.
   - Counters: rd_cnt=3, wr_cnt=2, err_cnt=1.
   - Forcing 65540 good reads leaves rd_cnt=16'hFFFF.
